// File: rtl/video_fetcher.sv
// video_fetcher: prefetch stage on the video read side of the memory manager.
//
// Walks videoAddress linearly through one frame of 8-bit pixels and pushes
// each returned byte into a small FIFO. The display timing logic pops one
// pixel per pixelRequest strobe, and the pixel appears one cycle later.
//
// Ports
//   clock          in   system clock, all logic on posedge
//   resetN         in   asynchronous active-low reset
//   frameStart     in   1-cycle pulse at start of vblank; flushes and restarts the fetch
//   pixelRequest   in   1-cycle pop strobe, one per displayed pixel
//   videoAddress   out  frame-relative pixel address to the memory manager
//   videoData      in   pixel byte from the memory manager
//   videoDataReady in   1-cycle strobe: videoData valid for videoAddress
//   pixelData      out  registered pixel to the display
//   pixelValid     out  pixelData was popped from the FIFO this cycle
//   fifoLevel      out  current FIFO occupancy, 0..FIFO_DEPTH
//   underflow      out  sticky: pop seen on an empty FIFO this frame
//   frameDone      out  last pixel of the frame has been accepted
module video_fetcher #(
   parameter int unsigned H_ACTIVE   = 320,
   parameter int unsigned V_ACTIVE   = 240,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                                clock,
   input  logic                                resetN,
   input  logic                                frameStart,
   input  logic                                pixelRequest,
   output logic [16:0]                         videoAddress,
   input  logic [7:0]                          videoData,
   input  logic                                videoDataReady,
   output logic [7:0]                          pixelData,
   output logic                                pixelValid,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifoLevel,
   output logic                                underflow,
   output logic                                frameDone
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned LvlW = $clog2(FIFO_DEPTH + 1);
   localparam logic [16:0]     LastAddr = 17'(H_ACTIVE * V_ACTIVE - 1);
   localparam logic [LvlW-1:0] FullLvl  = LvlW'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StFetch, StDone} state_e;

   state_e            state_q, state_d;
   logic [16:0]       addr_q, addr_d;
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LvlW-1:0]   level_q, level_d;
   logic [7:0]        pix_q, pix_d;
   logic              valid_q, valid_d;
   logic              uf_q, uf_d;
   logic              done_q, done_d;
   logic [7:0]        mem_q [FIFO_DEPTH];

   logic              pop;
   logic              push;

   always_comb begin
      pop  = 1'b0;
      push = 1'b0;
      state_d  = state_q;
      addr_d   = addr_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      pix_d    = pix_q;
      valid_d  = 1'b0;
      uf_d     = uf_q;
      done_d   = done_q;

      if (frameStart) begin
         // frameStart overrides any strobe or pop on the same edge.
         state_d  = StFetch;
         addr_d   = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         uf_d     = 1'b0;
         done_d   = 1'b0;
         if (pixelRequest) begin
            pix_d = 8'h00;
         end
      end else begin
         pop  = pixelRequest && (level_q != '0);
         // A pop on the same edge frees a slot, so a full FIFO can still accept.
         push = (state_q == StFetch) && videoDataReady && ((level_q < FullLvl) || pop);

         unique case (state_q)
            StIdle:  state_d = StIdle;
            StFetch: if (push && (addr_q == LastAddr)) state_d = StDone;
            StDone:  state_d = StDone;
            default: state_d = StIdle;
         endcase

         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (addr_q == LastAddr) begin
               addr_d = '0;
               done_d = 1'b1;
            end else begin
               addr_d = addr_q + 17'd1;
            end
         end

         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            pix_d    = mem_q[rd_ptr_q];
            valid_d  = 1'b1;
         end else if (pixelRequest) begin
            // Empty FIFO: show the border colour; a same-edge push is not bypassed.
            pix_d = 8'h00;
            uf_d  = 1'b1;
         end

         if (push && !pop) begin
            level_d = level_q + 1'b1;
         end else if (pop && !push) begin
            level_d = level_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         pix_q    <= '0;
         valid_q  <= 1'b0;
         uf_q     <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         pix_q    <= pix_d;
         valid_q  <= valid_d;
         uf_q     <= uf_d;
         done_q   <= done_d;
      end
   end

   // Storage needs no reset; occupancy is tracked by level_q and the pointers.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= videoData;
      end
   end

   assign videoAddress = addr_q;
   assign pixelData    = pix_q;
   assign pixelValid   = valid_q;
   assign fifoLevel    = level_q;
   assign underflow    = uf_q;
   assign frameDone    = done_q;

endmodule

// File: tb/tb_video_fetcher.sv
module tb_video_fetcher;

   logic        clock = 1'b0;
   logic        resetN = 1'b0;
   logic        frameStart = 1'b0;
   logic        pixelRequest = 1'b0;
   logic [7:0]  videoData = 8'h00;
   logic        videoDataReady = 1'b0;

   logic [16:0] videoAddress;
   logic [7:0]  pixelData;
   logic        pixelValid;
   logic [3:0]  fifoLevel;
   logic        underflow;
   logic        frameDone;

   logic [16:0] s_videoAddress;
   logic [7:0]  s_pixelData;
   logic        s_pixelValid;
   logic [3:0]  s_fifoLevel;
   logic        s_underflow;
   logic        s_frameDone;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   video_fetcher dut (
      .clock          (clock),
      .resetN         (resetN),
      .frameStart     (frameStart),
      .pixelRequest   (pixelRequest),
      .videoAddress   (videoAddress),
      .videoData      (videoData),
      .videoDataReady (videoDataReady),
      .pixelData      (pixelData),
      .pixelValid     (pixelValid),
      .fifoLevel      (fifoLevel),
      .underflow      (underflow),
      .frameDone      (frameDone)
   );

   // Small 4x2 frame sharing the same stimulus.
   video_fetcher #(.H_ACTIVE(4), .V_ACTIVE(2), .FIFO_DEPTH(8)) dut_s (
      .clock          (clock),
      .resetN         (resetN),
      .frameStart     (frameStart),
      .pixelRequest   (pixelRequest),
      .videoAddress   (s_videoAddress),
      .videoData      (videoData),
      .videoDataReady (videoDataReady),
      .pixelData      (s_pixelData),
      .pixelValid     (s_pixelValid),
      .fifoLevel      (s_fifoLevel),
      .underflow      (s_underflow),
      .frameDone      (s_frameDone)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic strobe(input logic [7:0] d);
      videoData      = d;
      videoDataReady = 1'b1;
      tick();
      videoDataReady = 1'b0;
      tick();
   endtask

   task automatic frame_start();
      frameStart = 1'b1;
      tick();
      frameStart = 1'b0;
   endtask

   task automatic pop();
      pixelRequest = 1'b1;
      tick();
      pixelRequest = 1'b0;
   endtask

   initial begin
      // Reset values
      #3;
      check_eq("rst_addr", 32'(videoAddress), 32'h0);
      check_eq("rst_pix", 32'(pixelData), 32'h0);
      check_eq("rst_valid", 32'(pixelValid), 32'h0);
      check_eq("rst_level", 32'(fifoLevel), 32'h0);
      check_eq("rst_uf", 32'(underflow), 32'h0);
      check_eq("rst_done", 32'(frameDone), 32'h0);
      tick();
      resetN = 1'b1;
      tick();

      // Strobe in IDLE is ignored
      strobe(8'hFF);
      check_eq("idle_addr", 32'(videoAddress), 32'h0);
      check_eq("idle_level", 32'(fifoLevel), 32'h0);

      // 1: four strobes then four pops
      frame_start();
      check_eq("t1_fs_addr", 32'(videoAddress), 32'h0);
      for (int i = 0; i < 4; i++) begin
         strobe(8'hA0 + 8'(i));
         check_eq("t1_addr", 32'(videoAddress), 32'(i + 1));
      end
      check_eq("t1_level", 32'(fifoLevel), 32'h4);
      for (int i = 0; i < 4; i++) begin
         pop();
         check_eq("t1_pix", 32'(pixelData), 32'hA0 + 32'(i));
         check_eq("t1_valid", 32'(pixelValid), 32'h1);
      end
      tick();
      check_eq("t1_hold_valid", 32'(pixelValid), 32'h0);
      check_eq("t1_hold_pix", 32'(pixelData), 32'hA3);
      check_eq("t1_empty", 32'(fifoLevel), 32'h0);

      // 2: fill, reject while full, then pop+strobe together
      frame_start();
      for (int i = 0; i < 8; i++) strobe(8'h10 + 8'(i));
      check_eq("t2_full", 32'(fifoLevel), 32'h8);
      check_eq("t2_addr8", 32'(videoAddress), 32'h8);
      strobe(8'hEE);
      strobe(8'hEE);
      check_eq("t2_rej_level", 32'(fifoLevel), 32'h8);
      check_eq("t2_rej_addr", 32'(videoAddress), 32'h8);
      pixelRequest   = 1'b1;
      videoDataReady = 1'b1;
      videoData      = 8'h18;
      tick();
      pixelRequest   = 1'b0;
      videoDataReady = 1'b0;
      check_eq("t2_pp_pix", 32'(pixelData), 32'h10);
      check_eq("t2_pp_level", 32'(fifoLevel), 32'h8);
      check_eq("t2_pp_addr", 32'(videoAddress), 32'h9);
      for (int i = 1; i <= 8; i++) begin
         pop();
         check_eq("t2_pix", 32'(pixelData), 32'h10 + 32'(i));
      end
      check_eq("t2_drained", 32'(fifoLevel), 32'h0);

      // 3: pop on empty
      pop();
      check_eq("t3_pix", 32'(pixelData), 32'h0);
      check_eq("t3_valid", 32'(pixelValid), 32'h0);
      check_eq("t3_uf", 32'(underflow), 32'h1);
      tick();
      check_eq("t3_uf_sticky", 32'(underflow), 32'h1);
      frame_start();
      check_eq("t3_uf_clr", 32'(underflow), 32'h0);
      check_eq("t3_level", 32'(fifoLevel), 32'h0);
      check_eq("t3_addr", 32'(videoAddress), 32'h0);

      // 4: small frame completes after 8 accepts
      frame_start();
      for (int i = 0; i < 7; i++) strobe(8'h70 + 8'(i));
      check_eq("t4_addr7", 32'(s_videoAddress), 32'h7);
      check_eq("t4_notdone", 32'(s_frameDone), 32'h0);
      strobe(8'h77);
      check_eq("t4_done", 32'(s_frameDone), 32'h1);
      check_eq("t4_wrap", 32'(s_videoAddress), 32'h0);
      check_eq("t4_level", 32'(s_fifoLevel), 32'h8);
      check_eq("t4_main_done", 32'(frameDone), 32'h0);
      pixelRequest   = 1'b1;
      videoDataReady = 1'b1;
      videoData      = 8'h99;
      tick();
      pixelRequest   = 1'b0;
      videoDataReady = 1'b0;
      check_eq("t4_nopush", 32'(s_fifoLevel), 32'h7);
      check_eq("t4_addr_hold", 32'(s_videoAddress), 32'h0);
      check_eq("t4_pix", 32'(s_pixelData), 32'h70);

      // 5: frameStart beats a same-edge strobe and pop
      frame_start();
      for (int i = 0; i < 5; i++) strobe(8'h50 + 8'(i));
      check_eq("t5_level5", 32'(fifoLevel), 32'h5);
      frameStart     = 1'b1;
      videoDataReady = 1'b1;
      pixelRequest   = 1'b1;
      videoData      = 8'hDD;
      tick();
      frameStart     = 1'b0;
      videoDataReady = 1'b0;
      pixelRequest   = 1'b0;
      check_eq("t5_level", 32'(fifoLevel), 32'h0);
      check_eq("t5_addr", 32'(videoAddress), 32'h0);
      check_eq("t5_pix", 32'(pixelData), 32'h0);
      check_eq("t5_valid", 32'(pixelValid), 32'h0);
      check_eq("t5_uf", 32'(underflow), 32'h0);
      strobe(8'h60);
      pop();
      check_eq("t5_head", 32'(pixelData), 32'h60);

      // 6: asynchronous reset mid-FETCH
      frame_start();
      for (int i = 0; i < 3; i++) strobe(8'h30 + 8'(i));
      check_eq("t6_level3", 32'(fifoLevel), 32'h3);
      pop();
      #2;
      resetN = 1'b0;
      #1;
      check_eq("t6_addr", 32'(videoAddress), 32'h0);
      check_eq("t6_level", 32'(fifoLevel), 32'h0);
      check_eq("t6_pix", 32'(pixelData), 32'h0);
      check_eq("t6_valid", 32'(pixelValid), 32'h0);
      tick();
      resetN = 1'b1;
      strobe(8'h44);
      check_eq("t6_idle_addr", 32'(videoAddress), 32'h0);
      check_eq("t6_idle_level", 32'(fifoLevel), 32'h0);
      frame_start();
      strobe(8'h45);
      check_eq("t6_restart", 32'(videoAddress), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
